// File: rtl/snn_img_sender.sv
// snn_img_sender: host-side image source for the SNN.
// Reads a binary image one pixel per cycle from a bit-addressed memory,
// packs it LSB-first into bytes, pushes each byte through a UART transmitter
// handshake and then waits for the single classification byte that comes back.
module snn_img_sender #(
    parameter int NUM_BITS       = 784,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [9:0] img_addr,
    input  logic       img_bit,
    output logic       trmt,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    input  logic       rx_rdy,
    input  logic [7:0] rx_data,
    output logic       busy,
    output logic       done,
    output logic [3:0] digit,
    output logic       resp_err,
    output logic       timeout
);

    localparam int NUM_BYTES = NUM_BITS / 8;
    localparam int TCW       = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [6:0]     LAST_BYTE = 7'(NUM_BYTES - 1);
    localparam logic [TCW-1:0] TC_LAST   = TCW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_SEND      = 3'd2,
        ST_WAIT_TX   = 3'd3,
        ST_WAIT_RESP = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    // A classification byte is only meaningful as a decimal digit 0..9.
    function automatic logic resp_valid(input logic [7:0] b);
        return (b[7:4] == 4'd0) && (b[3:0] <= 4'd9);
    endfunction

    state_t         state_r, state_s;
    logic [6:0]     byte_cnt_r, byte_cnt_s;
    logic [3:0]     bit_cnt_r, bit_cnt_s;
    logic [7:0]     shift_r, shift_s;
    logic [TCW-1:0] tmo_cnt_r, tmo_cnt_s;
    logic [9:0]     img_addr_s;
    logic [7:0]     tx_data_s;
    logic           trmt_s, busy_s, done_s, resp_err_s, timeout_s;
    logic [3:0]     digit_s;
    logic [2:0]     bit_idx_s;

    // The pixel arriving now belongs to the address presented one cycle earlier.
    assign bit_idx_s = bit_cnt_r[2:0] - 3'd1;

    // State, counters and all outputs are registered; reset aborts any transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            byte_cnt_r <= 7'd0;
            bit_cnt_r  <= 4'd0;
            shift_r    <= 8'd0;
            tmo_cnt_r  <= '0;
            img_addr   <= 10'd0;
            tx_data    <= 8'd0;
            trmt       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            digit      <= 4'd0;
            resp_err   <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_r    <= state_s;
            byte_cnt_r <= byte_cnt_s;
            bit_cnt_r  <= bit_cnt_s;
            shift_r    <= shift_s;
            tmo_cnt_r  <= tmo_cnt_s;
            img_addr   <= img_addr_s;
            tx_data    <= tx_data_s;
            trmt       <= trmt_s;
            busy       <= busy_s;
            done       <= done_s;
            digit      <= digit_s;
            resp_err   <= resp_err_s;
            timeout    <= timeout_s;
        end
    end

    // Next-state selection for the transfer sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_FETCH;
                else       state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (bit_cnt_r == 4'd8) state_s = ST_SEND;
                else                   state_s = ST_FETCH;
            end
            ST_SEND: begin
                state_s = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    if (byte_cnt_r == LAST_BYTE) state_s = ST_WAIT_RESP;
                    else                         state_s = ST_FETCH;
                end else begin
                    state_s = ST_WAIT_TX;
                end
            end
            ST_WAIT_RESP: begin
                if (rx_rdy || (tmo_cnt_r == TC_LAST)) state_s = ST_FINISH;
                else                                  state_s = ST_WAIT_RESP;
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the datapath and outputs, registered one cycle later.
    always_comb begin
        img_addr_s = img_addr;
        tx_data_s  = tx_data;
        byte_cnt_s = byte_cnt_r;
        bit_cnt_s  = bit_cnt_r;
        shift_s    = shift_r;
        tmo_cnt_s  = tmo_cnt_r;
        digit_s    = digit;
        resp_err_s = resp_err;
        timeout_s  = timeout;
        trmt_s     = (state_s == ST_SEND);
        done_s     = (state_s == ST_FINISH);
        busy_s     = (state_s == ST_FETCH) || (state_s == ST_SEND) ||
                     (state_s == ST_WAIT_TX) || (state_s == ST_WAIT_RESP);
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    resp_err_s = 1'b0;
                    timeout_s  = 1'b0;
                    byte_cnt_s = 7'd0;
                    bit_cnt_s  = 4'd0;
                    img_addr_s = 10'd0;
                end else begin
                    byte_cnt_s = byte_cnt_r;
                end
            end
            ST_FETCH: begin
                // Address runs 8 cycles and then holds on the byte's last pixel.
                if (bit_cnt_r < 4'd7) img_addr_s = img_addr + 10'd1;
                else                  img_addr_s = img_addr;
                if (bit_cnt_r != 4'd0) shift_s[bit_idx_s] = img_bit;
                else                   shift_s = shift_r;
                if (bit_cnt_r == 4'd8) begin
                    tx_data_s = shift_s;
                    bit_cnt_s = 4'd0;
                end else begin
                    bit_cnt_s = bit_cnt_r + 4'd1;
                end
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    if (byte_cnt_r == LAST_BYTE) begin
                        tmo_cnt_s = '0;
                    end else begin
                        byte_cnt_s = byte_cnt_r + 7'd1;
                        img_addr_s = {byte_cnt_r + 7'd1, 3'b000};
                        bit_cnt_s  = 4'd0;
                    end
                end else begin
                    tmo_cnt_s = tmo_cnt_r;
                end
            end
            ST_WAIT_RESP: begin
                tmo_cnt_s = tmo_cnt_r + TCW'(1);
                // A response arriving on the final count takes priority over expiry.
                if (rx_rdy) begin
                    if (resp_valid(rx_data)) digit_s = rx_data[3:0];
                    else                     resp_err_s = 1'b1;
                end else if (tmo_cnt_r == TC_LAST) begin
                    timeout_s = 1'b1;
                end else begin
                    timeout_s = timeout;
                end
            end
            default: begin
                shift_s = shift_r;
            end
        endcase
    end

endmodule

// File: tb/tb_snn_img_sender.sv
// Directed self-checking bench for snn_img_sender. Instance a uses the default
// timeout, instance b a 64-cycle timeout; sel routes the driven handshakes.
module tb_snn_img_sender;

    logic clk = 1'b0;
    logic rst;
    logic sel;
    logic start_v, tx_done_v, rx_rdy_v;
    logic [7:0] rx_data_v;

    logic       start_a, tx_done_a, rx_rdy_a, img_bit_a;
    logic [9:0] img_addr_a;
    logic       trmt_a, busy_a, done_a, resp_err_a, timeout_a;
    logic [7:0] tx_data_a;
    logic [3:0] digit_a;

    logic       start_b, tx_done_b, rx_rdy_b, img_bit_b;
    logic [9:0] img_addr_b;
    logic       trmt_b, busy_b, done_b, resp_err_b, timeout_b;
    logic [7:0] tx_data_b;
    logic [3:0] digit_b;

    logic       trmt_m, busy_m;
    logic [7:0] tx_data_m;
    logic [9:0] img_addr_m;

    logic [783:0] img;
    logic [7:0]   got [0:97];

    int checks = 0;
    int failures = 0;
    int nb, lat_first, lat_bad, busy_bad, stab_bad, max_addr;
    int bad, tr;
    bit aborted;

    always #5 clk = ~clk;

    assign start_a   = start_v & ~sel;
    assign tx_done_a = tx_done_v & ~sel;
    assign rx_rdy_a  = rx_rdy_v & ~sel;
    assign start_b   = start_v & sel;
    assign tx_done_b = tx_done_v & sel;
    assign rx_rdy_b  = rx_rdy_v & sel;

    assign trmt_m     = sel ? trmt_b : trmt_a;
    assign busy_m     = sel ? busy_b : busy_a;
    assign tx_data_m  = sel ? tx_data_b : tx_data_a;
    assign img_addr_m = sel ? img_addr_b : img_addr_a;

    always @(posedge clk) begin
        img_bit_a <= img[img_addr_a];
        img_bit_b <= img[img_addr_b];
    end

    snn_img_sender dut_a (
        .clk(clk), .rst(rst), .start(start_a), .img_addr(img_addr_a), .img_bit(img_bit_a),
        .trmt(trmt_a), .tx_data(tx_data_a), .tx_done(tx_done_a), .rx_rdy(rx_rdy_a),
        .rx_data(rx_data_v), .busy(busy_a), .done(done_a), .digit(digit_a),
        .resp_err(resp_err_a), .timeout(timeout_a)
    );

    snn_img_sender #(.NUM_BITS(784), .TIMEOUT_CYCLES(64)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .img_addr(img_addr_b), .img_bit(img_bit_b),
        .trmt(trmt_b), .tx_data(tx_data_b), .tx_done(tx_done_b), .rx_rdy(rx_rdy_b),
        .rx_data(rx_data_v), .busy(busy_b), .done(done_b), .digit(digit_b),
        .resp_err(resp_err_b), .timeout(timeout_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one transfer on the selected instance, answering each trmt with
    // tx_done dly cycles later. Returns at the negedge after the last tx_done
    // edge, or straight away (same negedge) when byte rst_at is loaded.
    task automatic xfer(input int dly, input bit stray, input int rst_at);
        int cyc, pend, last_done;
        bit last_sent;
        logic [7:0] cur;
        nb = 0; lat_first = -1; lat_bad = 0; busy_bad = 0; stab_bad = 0; max_addr = 0;
        aborted = 1'b0; cyc = 0; pend = 0; last_done = 0; last_sent = 1'b0; cur = 8'd0;
        start_v = 1'b1;
        while (cyc < 8000) begin
            @(negedge clk);
            cyc++;
            start_v = 1'b0; tx_done_v = 1'b0; rx_rdy_v = 1'b0;
            if (!busy_m) busy_bad++;
            if (int'(img_addr_m) > max_addr) max_addr = int'(img_addr_m);
            if (trmt_m) begin
                if (nb < 98) got[nb] = tx_data_m;
                if (nb == 0) lat_first = cyc;
                else if (cyc - last_done != 10) lat_bad++;
                nb++;
                cur = tx_data_m;
                pend = dly;
                if (rst_at >= 0 && nb == rst_at + 1) begin
                    aborted = 1'b1;
                    break;
                end
            end else if (pend > 0) begin
                if (tx_data_m !== cur) stab_bad++;
                pend--;
                if (pend == 0) begin
                    tx_done_v = 1'b1;
                    last_done = cyc;
                    if (nb >= 98) last_sent = 1'b1;
                end
            end
            if (last_sent && !tx_done_v) break;
            if (stray && (cyc == 5 || cyc == 200 || cyc == 1500)) begin
                start_v = 1'b1; rx_rdy_v = 1'b1; rx_data_v = 8'h03;
            end
        end
    endtask

    task automatic respond(input logic [7:0] d);
        rx_data_v = d;
        rx_rdy_v = 1'b1;
        @(negedge clk);
        rx_rdy_v = 1'b0;
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; start_v = 1'b0; tx_done_v = 1'b0; rx_rdy_v = 1'b0;
        rx_data_v = 8'h00; img = '0;
        repeat (3) @(negedge clk);
        chk("rst_img_addr", 32'(img_addr_a), 32'd0);
        chk("rst_tx_data", 32'(tx_data_a), 32'd0);
        chk("rst_trmt", 32'(trmt_a), 32'd0);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_digit", 32'(digit_a), 32'd0);
        chk("rst_status", 32'({resp_err_a, timeout_a}), 32'd0);
        chk("rst_b_all", 32'({trmt_b, busy_b, done_b, resp_err_b, timeout_b, digit_b, tx_data_b, img_addr_b}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // All-ones image, valid response 0x07 after 500 cycles.
        img = '1;
        xfer(20, 1'b0, -1);
        chk("ones_nbytes", 32'(nb), 32'd98);
        bad = 0;
        for (int k = 0; k < 98; k++) if (got[k] !== 8'hFF) bad++;
        chk("ones_bytes", 32'(bad), 32'd0);
        chk("first_latency", 32'(lat_first), 32'd10);
        chk("next_latency", 32'(lat_bad), 32'd0);
        chk("busy_during", 32'(busy_bad), 32'd0);
        chk("tx_data_stable", 32'(stab_bad), 32'd0);
        chk("max_img_addr", 32'(max_addr), 32'd783);
        tr = 0; bad = 0;
        repeat (499) begin
            @(negedge clk);
            if (trmt_m) tr++;
            if (!busy_m || done_a) bad++;
        end
        chk("no_trmt_after_last", 32'(tr), 32'd0);
        chk("busy_wait_resp", 32'(bad), 32'd0);
        respond(8'h07);
        chk("ok_done", 32'(done_a), 32'd1);
        chk("ok_digit", 32'(digit_a), 32'd7);
        chk("ok_status", 32'({resp_err_a, timeout_a}), 32'd0);
        chk("ok_busy", 32'(busy_a), 32'd0);
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        chk("done_single", 32'(done_a), 32'd0);
        chk("start_in_finish_ignored", 32'(busy_a), 32'd0);

        // Only pixel 0 set, out-of-range response 0x3A.
        img = '0; img[0] = 1'b1;
        xfer(20, 1'b0, -1);
        chk("p0_nbytes", 32'(nb), 32'd98);
        chk("p0_byte0", 32'(got[0]), 32'h01);
        bad = 0;
        for (int k = 1; k < 98; k++) if (got[k] !== 8'h00) bad++;
        chk("p0_others", 32'(bad), 32'd0);
        respond(8'h3A);
        chk("err3a_done", 32'(done_a), 32'd1);
        chk("err3a_resp_err", 32'(resp_err_a), 32'd1);
        chk("err3a_digit", 32'(digit_a), 32'd7);
        @(negedge clk);

        // Only pixel 783 set, boundary response 0x0A.
        img = '0; img[783] = 1'b1;
        xfer(20, 1'b0, -1);
        chk("resp_err_cleared", 32'(resp_err_a), 32'd0);
        chk("p783_byte97", 32'(got[97]), 32'h80);
        bad = 0;
        for (int k = 0; k < 97; k++) if (got[k] !== 8'h00) bad++;
        chk("p783_others", 32'(bad), 32'd0);
        respond(8'h0A);
        chk("err0a_resp_err", 32'(resp_err_a), 32'd1);
        chk("err0a_digit", 32'(digit_a), 32'd7);
        @(negedge clk);

        // Byte k carries value k; stray start/rx_rdy pulses while busy.
        for (int k = 0; k < 98; k++)
            for (int j = 0; j < 8; j++) img[8*k+j] = k[j];
        xfer(20, 1'b1, -1);
        chk("stray_nbytes", 32'(nb), 32'd98);
        bad = 0;
        for (int k = 0; k < 98; k++) if (got[k] !== 8'(k)) bad++;
        chk("stray_bytes", 32'(bad), 32'd0);
        chk("stray_busy", 32'(busy_bad), 32'd0);
        chk("stray_digit_kept", 32'(digit_a), 32'd7);
        respond(8'h09);
        chk("d9_digit", 32'(digit_a), 32'd9);
        chk("d9_status", 32'({done_a, resp_err_a, timeout_a}), 32'b100);
        @(negedge clk);

        // Reset while byte 40 is being loaded.
        img = '1;
        xfer(20, 1'b0, 40);
        chk("abort_reached", 32'(aborted), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_trmt", 32'(trmt_a), 32'd0);
        chk("abort_digit", 32'(digit_a), 32'd0);
        chk("abort_rest", 32'({busy_a, done_a, resp_err_a, timeout_a, tx_data_a, img_addr_a}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Timeout instance: no response, expiry 64 edges after last tx_done.
        sel = 1'b1;
        img = '0;
        xfer(3, 1'b0, -1);
        chk("tmo_nbytes", 32'(nb), 32'd98);
        repeat (63) @(negedge clk);
        chk("tmo_not_yet", 32'({timeout_b, done_b}), 32'd0);
        @(negedge clk);
        chk("tmo_flag", 32'(timeout_b), 32'd1);
        chk("tmo_done", 32'(done_b), 32'd1);
        chk("tmo_rest", 32'({busy_b, resp_err_b, digit_b}), 32'd0);
        @(negedge clk);
        chk("tmo_done_single", 32'(done_b), 32'd0);

        // Response on the final count wins over expiry.
        xfer(3, 1'b0, -1);
        chk("tmo_cleared", 32'(timeout_b), 32'd0);
        repeat (63) @(negedge clk);
        respond(8'h05);
        chk("tie_timeout", 32'(timeout_b), 32'd0);
        chk("tie_digit", 32'(digit_b), 32'd5);
        chk("tie_done", 32'(done_b), 32'd1);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snn_img_sender.md
Name: snn_img_sender

Overview:
Host-side counterpart of the SNN top level. It reads a 784-pixel binary image from a bit-addressed image memory and packs it LSB-first into 98 bytes. It drives those bytes to a byte-level UART transmitter, then waits for the single classification byte returned by the SNN through a byte-level UART receiver. It is used in FPGA loopback and system testbenches to stimulate the SNN end to end, and it reports the returned digit plus error and timeout status.

Parameters:
NUM_BITS, 784, image size in pixels; must be a multiple of 8; byte count NUM_BYTES = NUM_BITS/8 (98).
TIMEOUT_CYCLES, 1048576, cycles allowed between the last byte's tx_done and the response rx_rdy.

Ports:
clk  input  1  system clock; single clock domain.
rst  input  1  asynchronous active-high reset.
start  input  1  one-cycle pulse; begins a transfer when idle.
img_addr  output  10  pixel address into the image memory (0..NUM_BITS-1).
img_bit  input  1  pixel value; valid one cycle after img_addr is presented.
trmt  output  1  one-cycle pulse; UART transmitter loads tx_data.
tx_data  output  8  byte to transmit; held stable from trmt until tx_done.
tx_done  input  1  one-cycle pulse from the UART transmitter when the byte has been shifted out.
rx_rdy  input  1  one-cycle pulse; a received byte is valid on rx_data.
rx_data  input  8  received byte.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse at the end of a transfer (success, error or timeout).
digit  output  4  last classified digit; updated only on a valid response.
resp_err  output  1  sticky until next start: response byte out of range.
timeout  output  1  sticky until next start: no response within TIMEOUT_CYCLES.

Behaviour:
- Reset: state IDLE; img_addr=0, tx_data=0, trmt=0, busy=0, done=0, digit=0, resp_err=0, timeout=0; all counters cleared. Reset mid-transfer aborts immediately and trmt drops in the same cycle as rst asserts.
- States: IDLE, FETCH, SEND, WAIT_TX, WAIT_RESP, FINISH.
- IDLE: on start, clear resp_err/timeout, byte_cnt=0, bit_cnt=0, img_addr=0, go to FETCH. start in any other state is ignored.
- FETCH: img_addr = byte_cnt*8 + bit_cnt and advances every cycle for 8 cycles. The bit returned for address a is written to shift bit a%8, so pixel 8k is bit 0 of byte k. Capture is pipelined: 9 cycles per byte, with the last bit captured one cycle after the last address. Then go to SEND.
- SEND: tx_data = packed byte; trmt=1 for exactly one cycle; go to WAIT_TX.
- WAIT_TX: hold tx_data and wait for tx_done.
  - If byte_cnt == NUM_BYTES-1: go to WAIT_RESP and clear the timeout counter.
  - Otherwise: byte_cnt+1 and go to FETCH.
  - A tx_done seen in any other state is ignored.
- WAIT_RESP: the timeout counter increments each cycle.
  - On rx_rdy with rx_data[7:4]==0 and rx_data[3:0]<=9: digit <= rx_data[3:0].
  - On rx_rdy with rx_data[7:4]!=0 or rx_data[3:0]>9: resp_err=1 and digit unchanged.
  - If the counter reaches TIMEOUT_CYCLES-1 without rx_rdy: timeout=1.
  - Each of these goes to FINISH.
  - If rx_rdy and counter expiry coincide, rx_rdy wins and timeout stays 0.
- rx_rdy outside WAIT_RESP is ignored; no status change.
- FINISH: done=1 for one cycle, busy=0, go to IDLE. A start in that same cycle is ignored; it must arrive in IDLE.
- Latency: first trmt 10 cycles after start; each subsequent trmt 10 cycles after the preceding tx_done.
- byte_cnt is 7 bits and never wraps past NUM_BYTES-1. img_addr never exceeds NUM_BITS-1.

Test Plan:
- Image memory all ones; start; tx_done 20 cycles after each trmt → exactly 98 trmt pulses, each with tx_data=8'hFF; no trmt after byte 97; busy high throughout.
- Image with only pixel 0 set, and separately only pixel 783 set → byte 0 = 8'h01 with all others 00; byte 97 = 8'h80 with all others 00.
- After the last tx_done, drive rx_rdy with rx_data=8'h07 after 500 cycles → digit=7, done pulses once, resp_err=0, timeout=0, busy=0.
- Response rx_data=8'h3A → resp_err=1, digit keeps its previous value (7), done pulses.
- No response, with TIMEOUT_CYCLES overridden to 64 → timeout=1 exactly 64 cycles after the last tx_done, and done pulses. Then rx_rdy coinciding with the final count → timeout=0 and the digit is accepted.
- Assert rst during byte 40 with trmt high → trmt=0 in the same cycle and all outputs at reset values. Stray rx_rdy and start pulses while busy → no effect, and exactly 98 bytes are sent.
